// File: rtl/debug_dma_writer_pkg.sv
// Shared types and defaults for the USB receive DMA writer.
// Holds the transfer state encoding and the bus handshake helper.
package debug_dma_writer_pkg;

    localparam int DEFAULT_BANK_W = 4;
    localparam int DEFAULT_ADDR_W = 24;
    localparam int DEFAULT_LEN_W  = 20;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    // A bus request is taken in any cycle it is raised and the target is not stalling.
    function automatic logic bus_accept(input logic request, input logic stall);
        return request && !stall;
    endfunction

endpackage

// File: rtl/debug_dma_packer.sv
// Pops bytes from the USB RX FIFO and packs four of them big-endian into one word.
// word_valid pulses in the cycle the fourth byte is shifted in.
module debug_dma_packer
    import debug_dma_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch,
    input  logic        flush,
    input  logic        rx_empty,
    input  logic [7:0]  rx_data,
    output logic        rx_read,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [2:0] WORD_BYTES = 3'(BYTES_PER_WORD);

    logic [2:0] issued;
    logic [2:0] received;
    logic       in_flight;

    assign rx_read    = fetch && !rx_empty && (issued < WORD_BYTES);
    assign word_valid = fetch && in_flight && (received == WORD_BYTES - 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued    <= '0;
            received  <= '0;
            in_flight <= 1'b0;
            word      <= '0;
        end else if (flush) begin
            // The FIFO byte popped last cycle is dropped along with the partial word.
            issued    <= '0;
            received  <= '0;
            in_flight <= 1'b0;
            word      <= '0;
        end else begin
            in_flight <= rx_read;
            if (rx_read) begin
                issued <= issued + 3'd1;
            end
            if (in_flight) begin
                word     <= {word[23:0], rx_data};
                received <= received + 3'd1;
            end
            if (word_valid) begin
                issued   <= '0;
                received <= '0;
            end
        end
    end

endmodule

// File: rtl/debug_dma_writer.sv
// USB receive DMA engine: packs FIFO bytes into words and writes them to
// consecutive word addresses in one bank over the request/write/busy bus.
module debug_dma_writer
    import debug_dma_writer_pkg::*;
#(
    parameter int BANK_W = DEFAULT_BANK_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [BANK_W-1:0] i_bank,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LEN_W-1:0]  i_length,
    output logic              o_busy,
    input  logic              i_rx_empty,
    output logic              o_rx_read,
    input  logic [7:0]        i_rx_data,
    output logic              o_request,
    output logic              o_write,
    output logic [BANK_W-1:0] o_bank,
    output logic [ADDR_W-1:0] o_address,
    output logic [31:0]       o_data,
    input  logic              i_busy
);

    state_t            state;
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] address;
    logic [LEN_W-1:0]  remaining;
    logic              accept;
    logic              word_valid;

    assign accept = bus_accept(o_request, i_busy);

    debug_dma_packer u_packer (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .fetch      (state == FETCH),
        .flush      (i_stop),
        .rx_empty   (i_rx_empty),
        .rx_data    (i_rx_data),
        .rx_read    (o_rx_read),
        .word       (o_data),
        .word_valid (word_valid)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            bank      <= '0;
            address   <= '0;
            remaining <= '0;
            o_busy    <= 1'b0;
            o_request <= 1'b0;
        end else if (i_stop) begin
            // A write taken in the stop cycle still counts as done.
            if (accept) begin
                address   <= address + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_request <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start && (i_length != '0)) begin
                        bank      <= i_bank;
                        address   <= i_address;
                        remaining <= i_length;
                        state     <= FETCH;
                        o_busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (word_valid) begin
                        state     <= WRITE;
                        o_request <= 1'b1;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        address   <= address + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        o_request <= 1'b0;
                        if (remaining == LEN_W'(1)) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_busy    <= 1'b0;
                    o_request <= 1'b0;
                end
            endcase
        end
    end

    assign o_write   = o_request;
    assign o_bank    = bank;
    assign o_address = address;

endmodule
